// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, sequences ibus requests and presents instructions to IF/ID.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned PC raises if_adel instead of fetching, then waits for flush.
module if_fetch #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(32'hBFC00000)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          br_flag,
    input  logic [AW-1:0] br_addr,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    output logic          ibus_en,
    output logic [AW-1:0] ibus_addr,
    input  logic [DW-1:0] ibus_rdata,
    input  logic          ibus_ack,
    output logic [AW-1:0] if_pc,
    output logic [DW-1:0] if_inst,
    output logic          if_valid,
    output logic          if_adel
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pend_addr_q;
    logic [AW-1:0] if_pc_q;
    logic [DW-1:0] buf_inst_q;
    logic [DW-1:0] if_inst_q;
    logic          pend_br_q;
    logic          discard_q;
    logic          if_valid_q;
    logic          if_adel_q;

    logic          pc_ok;
    logic          ack;
    logic          br_take;
    logic [AW-1:0] next_pc_d;

    function automatic logic [AW-1:0] fix_pc(input logic [AW-1:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return a;
`else
        return a & ~AW'(3);
`endif
    endfunction

`ifdef FETCH_ALIGN_CHECK_EN
    assign pc_ok = (pc_q[1:0] == 2'b00);
`else
    assign pc_ok = 1'b1;
`endif

    assign ibus_en   = (state_q == S_REQ) && pc_ok;
    assign ibus_addr = pc_q;
    assign ack       = ibus_en && ibus_ack;
    // A branch resolved while the pipeline is being squashed belongs to a dead path.
    assign br_take   = br_flag && !discard_q;
    assign next_pc_d = br_take   ? br_addr     :
                       pend_br_q ? pend_addr_q :
                                   pc_q + AW'(4);

    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;
    assign if_adel  = if_adel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            pend_addr_q <= '0;
            buf_inst_q  <= '0;
            pend_br_q   <= 1'b0;
            discard_q   <= 1'b0;
            if_pc_q     <= '0;
            if_inst_q   <= '0;
            if_valid_q  <= 1'b0;
            if_adel_q   <= 1'b0;
        end else if (flush) begin
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            if_adel_q   <= 1'b0;
            pend_br_q   <= 1'b0;
            pend_addr_q <= flush_addr;
            // An outstanding request cannot be withdrawn; its ack must be swallowed first.
            if (ibus_en && !ibus_ack) begin
                discard_q <= 1'b1;
            end else begin
                discard_q <= 1'b0;
                pc_q      <= fix_pc(flush_addr);
                state_q   <= S_REQ;
            end
        end else begin
            if (br_take) begin
                pend_br_q   <= 1'b1;
                pend_addr_q <= br_addr;
            end
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (!pc_ok) begin
                        if (!stall) begin
                            if_pc_q    <= pc_q;
                            if_inst_q  <= '0;
                            if_valid_q <= 1'b1;
                            if_adel_q  <= 1'b1;
                            state_q    <= S_ERR;
                        end
                    end else if (ack) begin
                        if (discard_q) begin
                            discard_q <= 1'b0;
                            pc_q      <= fix_pc(pend_addr_q);
                        end else if (!stall) begin
                            if_pc_q    <= pc_q;
                            if_inst_q  <= ibus_rdata;
                            if_valid_q <= 1'b1;
                            if_adel_q  <= 1'b0;
                            pc_q       <= fix_pc(next_pc_d);
                            pend_br_q  <= 1'b0;
                        end else begin
                            buf_inst_q <= ibus_rdata;
                            state_q    <= S_HOLD;
                        end
                    end else if (!stall) begin
                        if_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_pc_q    <= pc_q;
                        if_inst_q  <= buf_inst_q;
                        if_valid_q <= 1'b1;
                        if_adel_q  <= 1'b0;
                        pc_q       <= fix_pc(next_pc_d);
                        pend_br_q  <= 1'b0;
                        state_q    <= S_REQ;
                    end
                end
                S_ERR: ;
            endcase
        end
    end

endmodule
